// File: rtl/csr_access_unit_if.sv
// Request/response bundle between an instruction pipeline, the CSR access unit and the CSR file.
// The slave modport is the access unit; the master modport is everything around it.
interface csr_access_unit_if;
    logic        start;
    logic [2:0]  funct3;
    logic [11:0] csr_addr_in;
    logic [4:0]  rs1_idx;
    logic [4:0]  rd_idx;
    logic [31:0] rs1_data;
    logic [31:0] csr_read_data;
    logic [11:0] csr_addr;
    logic        csr_read_en;
    logic        csr_write_en;
    logic [31:0] csr_write_data;
    logic        busy;
    logic        done;
    logic        illegal;
    logic        rd_wen;
    logic [31:0] rd_data;

    modport slave (
        input  start, funct3, csr_addr_in, rs1_idx, rd_idx, rs1_data, csr_read_data,
        output csr_addr, csr_read_en, csr_write_en, csr_write_data,
        output busy, done, illegal, rd_wen, rd_data
    );

    modport master (
        output start, funct3, csr_addr_in, rs1_idx, rd_idx, rs1_data, csr_read_data,
        input  csr_addr, csr_read_en, csr_write_en, csr_write_data,
        input  busy, done, illegal, rd_wen, rd_data
    );
endinterface

// File: rtl/csr_access_unit.sv
// Executes one Zicsr instruction as read/modify/write against a CSR file; 3 cycles start->done (2 if a phase is skipped, 1 if illegal).
// No backpressure: start is only honoured in IDLE and is dropped while busy.
module csr_access_unit #(
    parameter int unsigned IMPL_CHECK = 1
) (
    input logic              clk,
    input logic              reset,
    csr_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic [11:0] addr_q;
    logic [4:0]  rs1_idx_q;
    logic [4:0]  rd_idx_q;
    logic [31:0] rs1_data_q;
    logic [31:0] old_q;
    logic        did_read_q;
    logic [31:0] write_data_q;
    logic [31:0] rd_data_q;
    logic        busy_q;
    logic        done_q;
    logic        illegal_q;
    logic        rd_wen_q;
    logic        read_en_q;
    logic        write_en_q;

    function automatic logic [31:0] apply_op(input logic [1:0] op, input logic [31:0] old,
                                             input logic [31:0] src);
        case (op)
            2'b01:   return src;
            2'b10:   return old | src;
            default: return old & ~src;
        endcase
    endfunction

    function automatic logic impl_addr(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h305, 12'h341, 12'h342};
    endfunction

    logic        legal_in;
    logic        rw_in;
    logic        rw_q;
    logic [31:0] src_in;
    logic [31:0] src_q;

    assign legal_in = (bus.funct3[1:0] != 2'b00) && ((IMPL_CHECK == 0) || impl_addr(bus.csr_addr_in));
    assign rw_in    = (bus.funct3[1:0] == 2'b01);
    assign rw_q     = (funct3_q[1:0] == 2'b01);
    assign src_in   = bus.funct3[2] ? {27'b0, bus.rs1_idx} : bus.rs1_data;
    assign src_q    = funct3_q[2] ? {27'b0, rs1_idx_q} : rs1_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            funct3_q     <= '0;
            addr_q       <= '0;
            rs1_idx_q    <= '0;
            rd_idx_q     <= '0;
            rs1_data_q   <= '0;
            old_q        <= '0;
            did_read_q   <= 1'b0;
            write_data_q <= '0;
            rd_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
            rd_wen_q     <= 1'b0;
            read_en_q    <= 1'b0;
            write_en_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q   <= 1'b0;
                    rd_wen_q <= 1'b0;
                    if (bus.start) begin
                        funct3_q   <= bus.funct3;
                        addr_q     <= bus.csr_addr_in;
                        rs1_idx_q  <= bus.rs1_idx;
                        rd_idx_q   <= bus.rd_idx;
                        rs1_data_q <= bus.rs1_data;
                        illegal_q  <= !legal_in;
                        busy_q     <= 1'b1;
                        if (!legal_in) begin
                            state      <= DONE;
                            done_q     <= 1'b1;
                            rd_data_q  <= '0;
                            did_read_q <= 1'b0;
                        end else if (rw_in && bus.rd_idx == 5'd0) begin
                            // Plain write with rd=x0: the old value is never needed.
                            state        <= WRITE;
                            write_en_q   <= 1'b1;
                            write_data_q <= apply_op(bus.funct3[1:0], 32'd0, src_in);
                            did_read_q   <= 1'b0;
                        end else begin
                            state      <= READ;
                            read_en_q  <= 1'b1;
                            did_read_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    read_en_q <= 1'b0;
                    old_q     <= bus.csr_read_data;
                    if (!rw_q && rs1_idx_q == 5'd0) begin
                        state     <= DONE;
                        done_q    <= 1'b1;
                        rd_data_q <= bus.csr_read_data;
                        rd_wen_q  <= (rd_idx_q != 5'd0);
                    end else begin
                        // Modify from the live read data; old_q only lands at this same edge.
                        state        <= WRITE;
                        write_en_q   <= 1'b1;
                        write_data_q <= apply_op(funct3_q[1:0], bus.csr_read_data, src_q);
                    end
                end
                WRITE: begin
                    write_en_q <= 1'b0;
                    state      <= DONE;
                    done_q     <= 1'b1;
                    rd_data_q  <= did_read_q ? old_q : 32'd0;
                    rd_wen_q   <= did_read_q && (rd_idx_q != 5'd0);
                end
                DONE: begin
                    done_q   <= 1'b0;
                    rd_wen_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.csr_addr       = addr_q;
    assign bus.csr_read_en    = read_en_q;
    assign bus.csr_write_en   = write_en_q;
    assign bus.csr_write_data = write_data_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.illegal        = illegal_q;
    assign bus.rd_wen         = rd_wen_q;
    assign bus.rd_data        = rd_data_q;
endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench: a per-op plan of expected outputs keyed by cycle, checked every negedge against the DUT.
module tb_csr_access_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    csr_access_unit_if bus();
    csr_access_unit #(.IMPL_CHECK(1)) dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [31:0] INIT_300 = 32'h0000_0001;
    localparam logic [31:0] INIT_305 = 32'h0000_0010;
    localparam logic [31:0] INIT_341 = 32'hAAAA_5555;
    localparam logic [31:0] INIT_342 = 32'h0000_000B;

    // CSR file seen by the DUT
    logic [31:0] csr_file [0:4095];
    logic        mem_init = 1'b0;
    assign bus.csr_read_data = csr_file[bus.csr_addr];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4096; i++) csr_file[i] <= 32'd0;
            csr_file[12'h300] <= INIT_300;
            csr_file[12'h305] <= INIT_305;
            csr_file[12'h341] <= INIT_341;
            csr_file[12'h342] <= INIT_342;
            mem_init <= 1'b1;
        end else if (bus.csr_write_en) begin
            csr_file[bus.csr_addr] <= bus.csr_write_data;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        busy, rd_en, wr_en, done, rd_wen, illegal, chk_rd;
        logic [31:0] rd_data, wdata;
        logic [11:0] addr;
    } exp_t;

    exp_t        plan [int];
    logic [31:0] mdl_csr [0:4095];
    logic [31:0] hold_rd = 32'd0;
    logic        hold_ill = 1'b0;
    logic        hold_valid = 1'b1;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // Architectural model: what a Zicsr instruction must do, laid out over the cycles after acceptance.
    task automatic plan_op(input int base, input logic [2:0] f3, input logic [11:0] a,
                           input logic [4:0] rs1, input logic [4:0] rd, input logic [31:0] d,
                           output int lat);
        logic        legal, is_rw, do_read, do_write;
        logic [31:0] src, old, nv;
        exp_t        e;
        legal    = (f3[1:0] != 2'b00) &&
                   (a == 12'h300 || a == 12'h301 || a == 12'h305 || a == 12'h341 || a == 12'h342);
        is_rw    = (f3[1:0] == 2'b01);
        src      = f3[2] ? {27'd0, rs1} : d;
        old      = mdl_csr[a];
        do_read  = legal && !(is_rw && rd == 5'd0);
        do_write = legal && !(!is_rw && rs1 == 5'd0);
        nv       = is_rw ? src : (f3[1:0] == 2'b10) ? (old | src) : (old & ~src);
        lat      = legal ? 1 + int'(do_read) + int'(do_write) : 1;
        for (int k = 1; k <= lat; k++) begin
            e.busy    = 1'b1;
            e.rd_en   = do_read && k == 1;
            e.wr_en   = do_write && k == lat - 1;
            e.done    = (k == lat);
            e.rd_wen  = (k == lat) && legal && rd != 5'd0 && do_read;
            e.illegal = !legal;
            e.chk_rd  = do_read;
            e.rd_data = old;
            e.wdata   = nv;
            e.addr    = a;
            plan[base + k] = e;
        end
        if (do_write) mdl_csr[a] = nv;
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        logic in_op;
        if (reset) begin
            hold_rd    = 32'd0;
            hold_ill   = 1'b0;
            hold_valid = 1'b1;
        end
        in_op = !reset && plan.exists(cyc);
        if (in_op) begin
            e = plan[cyc];
        end else begin
            e.busy = 1'b0; e.rd_en = 1'b0; e.wr_en = 1'b0; e.done = 1'b0; e.rd_wen = 1'b0;
            e.illegal = hold_ill; e.chk_rd = hold_valid; e.rd_data = hold_rd;
            e.wdata = 32'd0; e.addr = 12'd0;
        end
        chk("busy", 32'(bus.busy), 32'(e.busy));
        chk("csr_read_en", 32'(bus.csr_read_en), 32'(e.rd_en));
        chk("csr_write_en", 32'(bus.csr_write_en), 32'(e.wr_en));
        chk("done", 32'(bus.done), 32'(e.done));
        chk("rd_wen", 32'(bus.rd_wen), 32'(e.rd_wen));
        if (e.rd_en || e.wr_en) chk("csr_addr", 32'(bus.csr_addr), 32'(e.addr));
        if (e.wr_en) chk("csr_write_data", bus.csr_write_data, e.wdata);
        if (e.done || !in_op) begin
            chk("illegal", 32'(bus.illegal), 32'(e.illegal));
            if (e.chk_rd) chk("rd_data", bus.rd_data, e.rd_data);
        end
        if (in_op && e.done) begin
            hold_ill   = e.illegal;
            hold_rd    = e.rd_data;
            hold_valid = e.chk_rd;
        end
    end

    task automatic drive(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1,
                         input logic [4:0] rd, input logic [31:0] d);
        bus.start       = 1'b1;
        bus.funct3      = f3;
        bus.csr_addr_in = a;
        bus.rs1_idx     = rs1;
        bus.rd_idx      = rd;
        bus.rs1_data    = d;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1,
                          input logic [4:0] rd, input logic [31:0] d, output int lat);
        @(posedge clk); #1;
        drive(f3, a, rs1, rd, d);
        plan_op(cyc, f3, a, rs1, rd, d, lat);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (lat + 2) @(posedge clk);
    endtask

    int          lat, lat_b;
    logic [31:0] saved;

    initial begin
        bus.start = 1'b0; bus.funct3 = 3'd0; bus.csr_addr_in = 12'd0;
        bus.rs1_idx = 5'd0; bus.rd_idx = 5'd0; bus.rs1_data = 32'd0;
        for (int i = 0; i < 4096; i++) mdl_csr[i] = 32'd0;
        mdl_csr[12'h300] = INIT_300;
        mdl_csr[12'h305] = INIT_305;
        mdl_csr[12'h341] = INIT_341;
        mdl_csr[12'h342] = INIT_342;

        repeat (3) @(posedge clk); #1;
        chk("reset_csr_addr", 32'(bus.csr_addr), 32'd0);
        chk("reset_write_data", bus.csr_write_data, 32'd0);
        chk("reset_rd_data", bus.rd_data, 32'd0);
        reset = 1'b0;

        // CSRRW mtvec
        run_op(3'b001, 12'h305, 5'd3, 5'd5, 32'h8000_0100, lat);
        chk("lat_csrrw", 32'(lat), 32'd3);
        chk("mtvec_written", csr_file[12'h305], 32'h8000_0100);

        // CSRRS then CSRRCI on mstatus
        run_op(3'b010, 12'h300, 5'd2, 5'd1, 32'h0000_0008, lat);
        chk("mstatus_set", csr_file[12'h300], 32'h0000_0009);
        run_op(3'b111, 12'h300, 5'd1, 5'd4, 32'hFFFF_FFFF, lat);
        chk("mstatus_clr", csr_file[12'h300], 32'h0000_0008);
        chk("model_mstatus", mdl_csr[12'h300], 32'h0000_0008);

        // Suppressed read / suppressed write
        run_op(3'b001, 12'h341, 5'd9, 5'd0, 32'h1234_5678, lat);
        chk("lat_rw_rd0", 32'(lat), 32'd2);
        chk("mepc_written", csr_file[12'h341], 32'h1234_5678);
        run_op(3'b010, 12'h342, 5'd0, 5'd7, 32'hFFFF_FFFF, lat);
        chk("lat_rs_rs10", 32'(lat), 32'd2);
        chk("mcause_kept", csr_file[12'h342], INIT_342);

        // Illegal: unimplemented address, reserved funct3 encodings
        run_op(3'b001, 12'h7C0, 5'd1, 5'd1, 32'h0000_0055, lat);
        chk("lat_illegal_addr", 32'(lat), 32'd1);
        chk("illegal_addr_nowrite", csr_file[12'h7C0], 32'd0);
        run_op(3'b100, 12'h300, 5'd1, 5'd1, 32'h0000_0055, lat);
        run_op(3'b000, 12'h305, 5'd1, 5'd1, 32'h0000_0055, lat);
        chk("illegal_f3_nowrite", csr_file[12'h300], 32'h0000_0008);

        // misa writes are forwarded
        run_op(3'b110, 12'h301, 5'd5, 5'd2, 32'd0, lat);
        chk("misa_forwarded", csr_file[12'h301], 32'h0000_0005);

        // start held across an op, then accepted again right after done
        @(posedge clk); #1;
        drive(3'b101, 12'h342, 5'd31, 5'd3, 32'd0);
        plan_op(cyc, 3'b101, 12'h342, 5'd31, 5'd3, 32'd0, lat);
        @(posedge clk); #1;
        drive(3'b011, 12'h342, 5'd6, 5'd8, 32'h0000_0003);
        repeat (lat) @(posedge clk);
        #1;
        plan_op(cyc, 3'b011, 12'h342, 5'd6, 5'd8, 32'h0000_0003, lat_b);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (lat_b + 2) @(posedge clk);
        chk("b2b_result", csr_file[12'h342], 32'h0000_001C);
        chk("model_b2b", mdl_csr[12'h342], 32'h0000_001C);

        // Reset while in READ
        @(posedge clk); #1;
        drive(3'b010, 12'h300, 5'd1, 5'd2, 32'h0000_00F0);
        saved = mdl_csr[12'h300];
        plan_op(cyc, 3'b010, 12'h300, 5'd1, 5'd2, 32'h0000_00F0, lat);
        @(posedge clk); #1;
        bus.start = 1'b0;
        #1;
        reset = 1'b1;
        plan.delete();
        mdl_csr[12'h300] = saved;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_read_en", 32'(bus.csr_read_en), 32'd0);
        chk("midrst_csr_addr", 32'(bus.csr_addr), 32'd0);
        chk("midrst_write_data", bus.csr_write_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        chk("midrst_no_write", csr_file[12'h300], 32'h0000_0008);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 SHALL have parameter IMPL_CHECK, default 1; when 1, addresses outside {0x300,0x301,0x305,0x341,0x342} are flagged illegal.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  in  1  one-cycle request; sampled only in IDLE.
REQ-005 SHALL have port funct3  in  3  CSR op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
REQ-006 SHALL have port csr_addr_in  in  12  target CSR address from instruction.
REQ-007 SHALL have port rs1_idx  in  5  rs1 index; also the zimm for the immediate ops.
REQ-008 SHALL have port rd_idx  in  5  destination register index.
REQ-009 SHALL have port rs1_data  in  32  rs1 register value.
REQ-010 SHALL have port csr_read_data  in  32  combinational read data returned by the CSR file.
REQ-011 SHALL have port csr_addr  out  12  address driven to the CSR file.
REQ-012 SHALL have port csr_read_en  out  1  read strobe to the CSR file.
REQ-013 SHALL have port csr_write_en  out  1  write strobe to the CSR file.
REQ-014 SHALL have port csr_write_data  out  32  write data to the CSR file.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.
REQ-016 SHALL have port done  out  1  one-cycle completion pulse.
REQ-017 SHALL have port illegal  out  1  valid with done; marks an illegal funct3 or address.
REQ-018 SHALL have port rd_wen  out  1  register-file write enable, valid with done.
REQ-019 SHALL have port rd_data  out  32  old CSR value for rd, valid with done.

Function
REQ-020 SHALL implement a Moore FSM with states IDLE, READ, WRITE and DONE; csr_read_en is high only in READ and csr_write_en is high only in WRITE.
REQ-021 SHALL latch funct3, csr_addr_in, rs1_idx, rd_idx and rs1_data when start=1 in IDLE; csr_addr SHALL be driven from the latched address.
REQ-022 SHALL ignore start while busy; no queueing.
REQ-023 SHALL define the source operand src as rs1_data when funct3[2]=0, else {27'b0, rs1_idx}.
REQ-024 SHALL suppress the read (IDLE->WRITE) for RW/RWI when rd_idx=0.
REQ-025 SHALL suppress the write (READ->DONE) for RS/RC/RSI/RCI when rs1_idx=0.
REQ-026 SHALL otherwise sequence IDLE->READ->WRITE->DONE->IDLE; full latency from start to done is 3 cycles, 2 cycles when a phase is suppressed.
REQ-027 SHALL register csr_read_data into an old-value register at the end of the READ cycle.
REQ-028 SHALL set csr_write_data to src for RW/RWI, old|src for RS/RSI, and old&~src for RC/RCI, all 32-bit with no carries.
REQ-029 SHALL treat funct3 000 or 100, or an unimplemented address when IDLE_CHECK... IMPL_CHECK=1, as illegal: IDLE->DONE with illegal=1, rd_wen=0, and no CSR strobes.
REQ-030 SHALL assert rd_wen in DONE only when the op is legal, rd_idx!=0 and READ was executed; rd_data SHALL equal the old value.
REQ-031 SHALL hold rd_data and illegal stable after DONE until the next accepted start.
REQ-032 SHALL allow a new start in the cycle after DONE, which is IDLE.
REQ-033 SHALL forward writes to 0x301 (misa) normally; discarding them is the CSR file's responsibility.

Reset
REQ-034 SHALL, on reset, go to IDLE asynchronously, including mid-operation; no write strobe may follow reset deassertion.
REQ-035 SHALL reset busy, done, illegal, rd_wen, csr_read_en and csr_write_en to 0.
REQ-036 SHALL reset csr_addr, csr_write_data, rd_data and the old-value register to 0.

Verification
REQ-037 SHALL verify CSRRW 0x305, rs1_data=0x80000100, rd=5, mtvec=0x10 -> READ then WRITE of 0x80000100; done on cycle 3 with rd_wen=1 and rd_data=0x10.
REQ-038 SHALL verify CSRRS 0x300 src=0x8, mstatus=0x1 -> write 0x9; CSRRCI 0x300 zimm=1 -> write 0x8, rd_data=0x9.
REQ-039 SHALL verify CSRRW with rd=0 -> no csr_read_en and done at cycle 2; CSRRS with rs1=0 -> no csr_write_en and rd_data=CSR value.
REQ-040 SHALL verify addr 0x7C0, or funct3=100 -> done at cycle 1, illegal=1, no strobes, rd_wen=0.
REQ-041 SHALL verify reset asserted in READ -> immediate return to IDLE, all outputs 0, no write afterwards.
REQ-042 SHALL verify start held high during busy -> exactly one operation, followed by a back-to-back start accepted in the cycle after done.
